// File: rtl/ledg_pattern_sequencer_if.sv
// Bus bundle for the LED pattern sequencer: the Avalon-MM config slave port
// plus the Avalon write port that drives the green-LED PIO s1 slave.
interface ledg_pattern_sequencer_if;
    logic [2:0]  cfg_address;
    logic        cfg_chipselect;
    logic        cfg_write_n;
    logic [31:0] cfg_writedata;
    logic [31:0] cfg_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        busy;

    // Sequencer side: config slave in, PIO master out.
    modport slave (
        input  cfg_address, cfg_chipselect, cfg_write_n, cfg_writedata,
        output cfg_readdata, pio_address, pio_chipselect, pio_write_n,
        output pio_writedata, busy
    );

    // Environment side: drives config accesses, observes the PIO writes.
    modport master (
        output cfg_address, cfg_chipselect, cfg_write_n, cfg_writedata,
        input  cfg_readdata, pio_address, pio_chipselect, pio_write_n,
        input  pio_writedata, busy
    );
endinterface

// File: rtl/ledg_pattern_sequencer.sv
// LED pattern sequencer: plays up to four 8-bit patterns into the green-LED
// PIO, holding each for a programmable number of clocks, looping or one-shot.
// Configured through a small zero-wait-state Avalon-MM slave.
module ledg_pattern_sequencer #(
    parameter int DWELL_W = 24,
    parameter int NUM_PAT = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    ledg_pattern_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    // Configuration and status registers
    logic               ctrl_en_r;
    logic               ctrl_oneshot_r;
    logic [1:0]         ctrl_last_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [7:0]         pat_r [NUM_PAT];
    logic               done_r;

    // Sequencer state
    state_t             state_r;
    logic [1:0]         idx_r;
    logic [DWELL_W-1:0] cnt_r;

    // Registered PIO outputs
    logic [1:0]         pio_address_r;
    logic               pio_chipselect_r;
    logic               pio_write_n_r;
    logic [31:0]        pio_writedata_r;

    // Decode and next-step signals
    logic               cfg_wr_s;
    logic               ctrl_wr_s;
    logic               ctrl_dis_s;
    logic               ctrl_en_wr_s;
    logic               status_wr_s;
    logic               pat_wr_s;
    logic               dwell_wr_s;
    logic               at_last_s;
    logic               dwell_end_s;
    logic               complete_s;
    logic               issue_s;
    logic [1:0]         issue_idx_s;
    logic [DWELL_W-1:0] cnt_load_s;
    logic               busy_s;
    logic [31:0]        readdata_s;
    logic               unused_wdata_s;

    // Bits above the widest register field are never stored.
    assign unused_wdata_s = ^bus.cfg_writedata[31:24];

    // Write decode and the conditions that steer the sequencer this cycle.
    always_comb begin
        cfg_wr_s     = bus.cfg_chipselect & ~bus.cfg_write_n;
        ctrl_wr_s    = cfg_wr_s && (bus.cfg_address == 3'd0);
        dwell_wr_s   = cfg_wr_s && (bus.cfg_address == 3'd1);
        status_wr_s  = cfg_wr_s && (bus.cfg_address == 3'd2);
        pat_wr_s     = cfg_wr_s && bus.cfg_address[2];
        ctrl_dis_s   = ctrl_wr_s && !bus.cfg_writedata[0];
        ctrl_en_wr_s = ctrl_wr_s && bus.cfg_writedata[0];
        // ">=" rather than "==" so a shrunk L wraps right after the current entry.
        at_last_s    = (idx_r >= ctrl_last_r);
        dwell_end_s  = (state_r == ST_DWELL) && (cnt_r == CNT_ONE);
        complete_s   = dwell_end_s && at_last_s && ctrl_oneshot_r;
        // A disable write suppresses any strobe that would start next cycle.
        issue_s      = !ctrl_dis_s &&
                       (((state_r == ST_IDLE) && ctrl_en_r) ||
                        (dwell_end_s && !complete_s));
        if (state_r == ST_IDLE) begin
            issue_idx_s = 2'd0;
        end else if (at_last_s) begin
            issue_idx_s = 2'd0;
        end else begin
            issue_idx_s = idx_r + 2'd1;
        end
        // A zero dwell behaves as a one-clock dwell.
        cnt_load_s = (dwell_r == CNT_ZERO) ? CNT_ONE : dwell_r;
        busy_s     = (state_r != ST_IDLE);
    end

    // Zero-wait-state register read mux; unused bits and holes read zero.
    always_comb begin
        readdata_s = 32'd0;
        case (bus.cfg_address)
            3'd0:    readdata_s = {26'd0, ctrl_last_r, 2'b00, ctrl_oneshot_r, ctrl_en_r};
            3'd1:    readdata_s = 32'(dwell_r);
            3'd2:    readdata_s = {27'd0, done_r, idx_r, 1'b0, busy_s};
            3'd4,
            3'd5,
            3'd6,
            3'd7:    readdata_s = {24'd0, pat_r[bus.cfg_address[1:0]]};
            default: readdata_s = 32'd0;
        endcase
    end

    // Software-owned pattern table and dwell length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell_r <= CNT_ZERO;
            for (int i = 0; i < NUM_PAT; i++) begin
                pat_r[i] <= 8'd0;
            end
        end else begin
            if (dwell_wr_s) begin
                dwell_r <= bus.cfg_writedata[DWELL_W-1:0];
            end
            if (pat_wr_s) begin
                pat_r[bus.cfg_address[1:0]] <= bus.cfg_writedata[7:0];
            end
        end
    end

    // Sequencer FSM with CTRL/done ownership and registered PIO strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            idx_r            <= 2'd0;
            cnt_r            <= CNT_ZERO;
            ctrl_en_r        <= 1'b0;
            ctrl_oneshot_r   <= 1'b0;
            ctrl_last_r      <= 2'd0;
            done_r           <= 1'b0;
            pio_address_r    <= 2'd0;
            pio_chipselect_r <= 1'b0;
            pio_write_n_r    <= 1'b1;
            pio_writedata_r  <= 32'd0;
        end else begin
            // The strobe is high exactly during the WRITE state.
            pio_address_r    <= 2'd0;
            pio_chipselect_r <= issue_s;
            pio_write_n_r    <= ~issue_s;
            if (issue_s) begin
                pio_writedata_r <= {24'd0, pat_r[issue_idx_s]};
            end

            if (ctrl_dis_s) begin
                state_r <= ST_IDLE;
                idx_r   <= 2'd0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        idx_r <= 2'd0;
                        if (ctrl_en_r) begin
                            state_r <= ST_WRITE;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_WRITE: begin
                        cnt_r   <= cnt_load_s;
                        state_r <= ST_DWELL;
                    end
                    ST_DWELL: begin
                        cnt_r <= cnt_r - CNT_ONE;
                        if (complete_s) begin
                            idx_r   <= 2'd0;
                            state_r <= ST_IDLE;
                        end else if (dwell_end_s) begin
                            idx_r   <= issue_idx_s;
                            state_r <= ST_WRITE;
                        end else begin
                            state_r <= ST_DWELL;
                        end
                    end
                    default: begin
                        idx_r   <= 2'd0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end

            // CTRL: software write wins over the one-shot auto-clear of enable.
            if (ctrl_wr_s) begin
                ctrl_en_r      <= bus.cfg_writedata[0];
                ctrl_oneshot_r <= bus.cfg_writedata[1];
                ctrl_last_r    <= bus.cfg_writedata[5:4];
            end else if (complete_s) begin
                ctrl_en_r <= 1'b0;
            end else begin
                ctrl_en_r <= ctrl_en_r;
            end

            // done: an enabling restart clears it, completion sets it, and the
            // set beats a coincident STATUS-write clear.
            if (ctrl_en_wr_s) begin
                done_r <= 1'b0;
            end else if (complete_s && !ctrl_wr_s) begin
                done_r <= 1'b1;
            end else if (status_wr_s) begin
                done_r <= 1'b0;
            end else begin
                done_r <= done_r;
            end
        end
    end

    assign bus.cfg_readdata   = readdata_s;
    assign bus.pio_address    = pio_address_r;
    assign bus.pio_chipselect = pio_chipselect_r;
    assign bus.pio_write_n    = pio_write_n_r;
    assign bus.pio_writedata  = pio_writedata_r;
    assign bus.busy           = busy_s;

endmodule

// File: tb/tb_ledg_pattern_sequencer.sv
// Scoreboard bench for ledg_pattern_sequencer: each expected PIO strobe
// (pattern and cycle) is queued as stimulus is issued; a monitor pops and
// compares whenever the DUT presents a strobe.
module tb_ledg_pattern_sequencer;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   last_wr;
    int   checks;
    int   errors;
    exp_t sb[$];

    ledg_pattern_sequencer_if bus ();

    ledg_pattern_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle index used for strobe timing.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        bus.cfg_address    = a;
        bus.cfg_chipselect = 1'b1;
        bus.cfg_write_n    = 1'b0;
        bus.cfg_writedata  = d;
        last_wr            = cyc;
        @(posedge clk);
        #1;
        bus.cfg_chipselect = 1'b0;
        bus.cfg_write_n    = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfg_read(input logic [2:0] a, input logic [31:0] exp, input string name);
        bus.cfg_address    = a;
        bus.cfg_chipselect = 1'b1;
        bus.cfg_write_n    = 1'b1;
        #1;
        check(name, bus.cfg_readdata, exp);
        bus.cfg_chipselect = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.pio_chipselect && !bus.pio_write_n) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got data 0x%0h at cycle %0d, required no strobe",
                         bus.pio_writedata, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_data", bus.pio_writedata, {24'd0, e.data});
                check("strobe_cycle", 32'(cyc), 32'(e.cyc));
                check("strobe_addr", {30'd0, bus.pio_address}, 32'd0);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        logic [7:0] lp [4];
        checks = 0;
        errors = 0;
        last_wr = 0;
        reset_n = 1'b0;
        bus.cfg_address    = 3'd0;
        bus.cfg_chipselect = 1'b0;
        bus.cfg_write_n    = 1'b1;
        bus.cfg_writedata  = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_write_n", {31'd0, bus.pio_write_n}, 32'd1);
        check("rst_cs", {31'd0, bus.pio_chipselect}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_wdata", bus.pio_writedata, 32'd0);
        cfg_read(3'd2, 32'h0, "rst_status");
        cfg_read(3'd0, 32'h0, "rst_ctrl");
        reset_n = 1'b1;
        @(negedge clk);

        // Looping sequence, then abort during a dwell
        lp[0] = 8'h01; lp[1] = 8'h02; lp[2] = 8'h04; lp[3] = 8'h08;
        cfg_write(3'd4, 32'h01);
        cfg_write(3'd5, 32'h02);
        cfg_write(3'd6, 32'h04);
        cfg_write(3'd7, 32'h08);
        cfg_write(3'd1, 32'd3);
        cfg_write(3'd0, 32'h31);
        k = last_wr;
        for (int i = 0; i < 6; i++) push_exp(lp[i % 4], k + 2 + 4 * i);
        wait_to(k + 3);
        check("loop_busy", {31'd0, bus.busy}, 32'd1);
        cfg_read(3'd2, 32'h01, "loop_status_idx0");
        wait_to(k + 7);
        cfg_read(3'd2, 32'h05, "loop_status_idx1");
        wait_to(k + 24);
        cfg_write(3'd0, 32'h0);
        wait_to(k + 40);
        cfg_read(3'd2, 32'h0, "abort_status");
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_hold", bus.pio_writedata, 32'h02);
        check("abort_drain", 32'(sb.size()), 32'd0);

        // Live pattern update while running
        cfg_write(3'd0, 32'h31);
        k = last_wr;
        push_exp(8'h01, k + 2);
        push_exp(8'h02, k + 6);
        push_exp(8'hC3, k + 10);
        push_exp(8'h08, k + 14);
        wait_to(k + 7);
        cfg_write(3'd6, 32'hC3);
        wait_to(k + 16);
        cfg_write(3'd0, 32'h0);
        wait_to(k + 30);
        check("live_drain", 32'(sb.size()), 32'd0);

        // DWELL=0, L=0 loop: 0xFF every 2 cycles; disable on a cnt==1 cycle
        cfg_write(3'd4, 32'hFF);
        cfg_write(3'd1, 32'd0);
        cfg_write(3'd0, 32'h01);
        k = last_wr;
        for (int i = 0; i < 4; i++) push_exp(8'hFF, k + 2 + 2 * i);
        wait_to(k + 9);
        cfg_write(3'd0, 32'h0);
        wait_to(k + 20);
        check("dw0_drain", 32'(sb.size()), 32'd0);

        // One-shot of two entries, then done handling
        cfg_write(3'd4, 32'hAA);
        cfg_write(3'd5, 32'h55);
        cfg_write(3'd1, 32'd5);
        cfg_write(3'd0, 32'h13);
        k = last_wr;
        push_exp(8'hAA, k + 2);
        push_exp(8'h55, k + 8);
        wait_to(k + 25);
        check("os_drain", 32'(sb.size()), 32'd0);
        check("os_busy", {31'd0, bus.busy}, 32'd0);
        cfg_read(3'd2, 32'h10, "os_status_done");
        cfg_read(3'd0, 32'h12, "os_ctrl");
        cfg_write(3'd3, 32'hFFFF_FFFF);
        cfg_read(3'd3, 32'h0, "addr3_reads0");
        cfg_read(3'd2, 32'h10, "os_done_kept");
        cfg_write(3'd2, 32'h0);
        cfg_read(3'd2, 32'h0, "done_cleared");
        cfg_read(3'd1, 32'd5, "dwell_read");
        cfg_read(3'd5, 32'h55, "pat1_read");

        // Reset asserted mid-run
        cfg_write(3'd0, 32'h31);
        k = last_wr;
        push_exp(8'hAA, k + 2);
        push_exp(8'h55, k + 8);
        wait_to(k + 9);
        reset_n = 1'b0;
        #1;
        check("mid_rst_write_n", {31'd0, bus.pio_write_n}, 32'd1);
        check("mid_rst_cs", {31'd0, bus.pio_chipselect}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        cfg_read(3'd2, 32'h0, "mid_rst_status");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        cfg_read(3'd0, 32'h0, "post_rst_ctrl");
        cfg_read(3'd1, 32'h0, "post_rst_dwell");
        cfg_read(3'd4, 32'h0, "post_rst_pat0");
        check("final_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
